ifetch_prefetch_unit: RTL and testbench
=======================================

// Module: ifetch_prefetch_unit
// PURPOSE
//  Parametrised instruction fetch stage with an in-order prefetch queue and a branch redirect input.
//  Issues word requests to instruction memory over a valid/ready request channel.
//  Accepts in-order responses and presents {pc, instruction} to decode over a valid/ready channel.
//  Discards responses made stale by a redirect, so decode never sees a wrong-path instruction.
// PARAMETERS
//  XLEN      32   address and instruction width in bits; PC step is XLEN/8 bytes
//  FQ_DEPTH  4    prefetch queue entries and max (queued + outstanding) requests; power of 2, >=2
//  RESET_PC  0    PC fetched first after reset
// PORTS
//  clk             in   1     clock; all state updates on posedge
//  rst_n           in   1     asynchronous reset, active-low
//  redirect_valid  in   1     taken branch/jump this cycle
//  redirect_pc     in   XLEN  target; low log2(XLEN/8) bits ignored (forced to 0)
//  mem_req_valid   out  1     fetch request valid
//  mem_req_ready   in   1     memory accepts request
//  mem_req_addr    out  XLEN  word-aligned byte address
//  mem_rsp_valid   in   1     response valid; responses in request order; never back-pressured
//  mem_rsp_data    in   XLEN  instruction word, little-endian
//  inst_valid      out  1     queue head valid
//  inst_ready      in   1     decode accepts head
//  inst_pc         out  XLEN  PC of head
//  inst_data       out  XLEN  instruction of head
// BEHAVIOUR
//  Reset (async assert): pc_q=RESET_PC; queue empty; outstanding=0; drop_cnt=0.
//   Outputs after reset: mem_req_valid=0, inst_valid=0, inst_pc=0, inst_data=0.
//  Issue: mem_req_valid=1 when !redirect_valid and (count+outstanding)<FQ_DEPTH; mem_req_addr=pc_q.
//   On req handshake: pc_q+=XLEN/8 (wraps modulo 2^XLEN); outstanding+=1.
//  Response: each mem_rsp_valid decrements outstanding.
//   If drop_cnt>0, decrement drop_cnt and discard; else push {pc_resp,data}.
//   pc_resp comes from an in-order PC shadow FIFO or a counter.
//   Credits guarantee no push when full; a response push does not overflow the queue.
//  Output: inst_* driven from queue head (registered). Pop on inst_valid&&inst_ready.
//   Push and pop in the same cycle are both honoured.
//  Latency: response cycle N -> inst_valid at N+1. Streaming at 1 instr/cycle with 1-cycle memory.
//  Redirect (highest priority, same cycle):
//   Flush queue; ignore any pop and push in that cycle.
//   pc_q=aligned redirect_pc; no request issued that cycle; first new request issued the next cycle.
//   drop_cnt = outstanding + drop_cnt - (mem_rsp_valid ? 1 : 0), i.e. every still-in-flight response is discarded.
//  Back-to-back redirects: the last one wins; drop_cnt accumulates as above; no stale word is ever delivered.
//  Reset mid-operation: all state cleared immediately; memory must also be reset.
// CONFIGURATION
//  IFETCH_PERF_EN defined: adds outputs perf_fetched, perf_redirects, perf_stall (32 bits each, reset 0, wrapping).
//   perf_fetched increments on each inst pop.
//   perf_redirects increments on each redirect_valid.
//   perf_stall increments each cycle the queue is full with inst_ready=0.
//  IFETCH_PERF_EN undefined: no perf ports or logic; functional behaviour is identical.
// STRUCTURE
//  ifetch_pkg: FETCH_BYTES=XLEN/8 constant; typedef fetch_entry_t {pc, insn}; ptr/count width helper.
//  Sub-module ifetch_queue: sync FIFO of fetch_entry_t, FQ_DEPTH entries, push/pop/flush, count output.
//  Top level holds pc_q, outstanding/drop counters, issue logic and perf counters.
// TESTING
//  1 Reset: hold rst_n=0, then release -> cycle 1 mem_req_valid=1, addr=0x0; inst_valid=0 until first response.
//  2 Stream: 1-cycle memory, inst_ready=1, mem[i]=0x1000+i -> inst_pc 0,4,8,C on consecutive cycles,
//    inst_data 0x1000..0x1003.
//  3 Backpressure: inst_ready=0 -> exactly 4 requests (0x0..0xC), then mem_req_valid=0.
//    Raise ready -> 4 pops in order, fetch resumes at 0x10.
//  4 Stale drop: 3-cycle memory, 2 outstanding, redirect_pc=0x103 -> both stale responses discarded,
//    next mem_req_addr=0x100, first inst_pc=0x100.
//  5 Redirect vs pop: queue full, inst_ready=1 and redirect_valid same cycle -> next cycle inst_valid=0,
//    popped entry not counted, pc_q=target.
//  6 Perf (IFETCH_PERF_EN): 10 pops, 2 redirects, 5 full-stall cycles -> perf counters read 10/2/5.
//    Without the macro the perf ports are absent.

Source files
------------

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared constants, the fetch queue entry type and width helpers
// for the instruction fetch / prefetch unit.
//   DEFAULT_XLEN  - default address/instruction width
//   FETCH_BYTES   - PC step in bytes for the default width
//   fetch_entry_t - {pc, insn} pair held in the prefetch queue
//   fetch_bytes() - PC step for an arbitrary XLEN
//   cnt_width()   - width of a counter able to hold 0..depth
package ifetch_pkg;

    localparam int unsigned DEFAULT_XLEN = 32;
    localparam int unsigned FETCH_BYTES  = DEFAULT_XLEN / 8;

    typedef struct packed {
        logic [DEFAULT_XLEN-1:0] pc;
        logic [DEFAULT_XLEN-1:0] insn;
    } fetch_entry_t;

    function automatic int unsigned fetch_bytes(input int unsigned xlen);
        return xlen / 8;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ifetch_queue.sv
// ifetch_queue: synchronous FIFO holding fetched {pc, insn} entries.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   push        - write push_data at the tail
//   push_data   - entry to write
//   pop         - drop the head entry
//   flush       - empty the queue; overrides push and pop
//   head        - entry at the head (registered storage, zero after reset)
//   count       - number of valid entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
module ifetch_queue
    import ifetch_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = fetch_entry_t
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  entry_t                      push_data,
    input  logic                        pop,
    input  logic                        flush,
    output entry_t                      head,
    output logic [cnt_width(DEPTH)-1:0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = cnt_width(DEPTH);

    entry_t          mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/ifetch_prefetch_unit.sv
// ifetch_prefetch_unit: instruction fetch stage with an in-order prefetch
// queue and a branch redirect input.
// Ports:
//   clk, rst_n                   - clock, asynchronous active-low reset
//   redirect_valid, redirect_pc  - taken branch/jump and its target
//   mem_req_valid/ready/addr     - word fetch request channel
//   mem_rsp_valid/data           - in-order responses, never back-pressured
//   inst_valid/ready/pc/data     - {pc, instruction} towards decode
//   perf_fetched/redirects/stall - event counters (only with IFETCH_PERF_EN)
// Optional feature macro: IFETCH_PERF_EN adds the three perf counter outputs.
module ifetch_prefetch_unit
    import ifetch_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     FQ_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_pc,
    output logic [XLEN-1:0] inst_data
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_redirects,
    output logic [31:0]     perf_stall
`endif
);

    localparam int unsigned STEP = fetch_bytes(XLEN);
    localparam int unsigned CW   = cnt_width(FQ_DEPTH);
    // Stale responses from several back-to-back redirects can pile up,
    // so the drop counter gets headroom beyond one queue's worth.
    localparam int unsigned DW   = CW + 3;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] insn;
    } entry_t;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] rsp_pc;
    logic [XLEN-1:0] target;
    logic [CW-1:0]   count;
    logic [CW-1:0]   outstanding;
    logic [DW-1:0]   drop_cnt;
    logic            started;
    logic            req_fire;
    logic            rsp_live;
    logic            push;
    logic            pop;
    entry_t          push_data;
    entry_t          head;

    assign target    = redirect_pc & ~XLEN'(STEP - 1);

    // No request while reset is in effect; fetch begins the cycle after release.
    assign mem_req_valid = started && !redirect_valid &&
                           (({1'b0, count} + {1'b0, outstanding}) < (CW + 1)'(FQ_DEPTH));
    assign mem_req_addr  = pc_q;
    assign req_fire      = mem_req_valid && mem_req_ready;

    assign rsp_live  = mem_rsp_valid && (drop_cnt == '0);
    assign push      = rsp_live && !redirect_valid;
    assign pop       = inst_valid && inst_ready && !redirect_valid;
    assign push_data = '{pc: rsp_pc, insn: mem_rsp_data};

    assign inst_valid = (count != '0);
    assign inst_pc    = head.pc;
    assign inst_data  = head.insn;

    // outstanding counts only right-path requests. A redirect moves every
    // in-flight request into drop_cnt, so drop_cnt = outstanding + drop_cnt
    // - (response this cycle) is exact and responses are consumed from
    // drop_cnt first. rsp_pc tracks the PC of the next right-path response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started     <= 1'b0;
            pc_q        <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            started <= 1'b1;
            if (redirect_valid) begin
                pc_q        <= target;
                rsp_pc      <= target;
                outstanding <= '0;
                drop_cnt    <= drop_cnt + DW'(outstanding) - DW'(mem_rsp_valid);
            end else begin
                if (req_fire) begin
                    pc_q <= pc_q + XLEN'(STEP);
                end
                if (rsp_live) begin
                    rsp_pc <= rsp_pc + XLEN'(STEP);
                end
                outstanding <= outstanding + CW'(req_fire) - CW'(rsp_live);
                if (mem_rsp_valid && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - 1'b1;
                end
            end
        end
    end

    ifetch_queue #(
        .DEPTH   (FQ_DEPTH),
        .entry_t (entry_t)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head),
        .count     (count)
    );

`ifdef IFETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched   <= '0;
            perf_redirects <= '0;
            perf_stall     <= '0;
        end else begin
            if (pop) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (redirect_valid) begin
                perf_redirects <= perf_redirects + 32'd1;
            end
            if ((count == CW'(FQ_DEPTH)) && !inst_ready) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_prefetch_unit.sv
`timescale 1ns/1ps
module tb_ifetch_prefetch_unit;
    import ifetch_pkg::*;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [XLEN-1:0] mem_req_addr;
    logic            mem_rsp_valid;
    logic [XLEN-1:0] mem_rsp_data;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst_pc;
    logic [XLEN-1:0] inst_data;
`ifdef IFETCH_PERF_EN
    logic [31:0]     perf_fetched;
    logic [31:0]     perf_redirects;
    logic [31:0]     perf_stall;
`endif

    ifetch_prefetch_unit #(
        .XLEN     (XLEN),
        .FQ_DEPTH (DEPTH),
        .RESET_PC (32'h0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_pc        (inst_pc),
        .inst_data      (inst_data)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_redirects (perf_redirects),
        .perf_stall     (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
        int unsigned tag;
    } mreq_t;

    mreq_t        mem_pipe[$];   // requests accepted by the memory model
    fetch_entry_t sb[$];         // expected instructions in delivery order

    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned cyc, lat, epoch, occ;
    int unsigned n_pops, n_redirects, n_stalls, n_reqs;
    int unsigned first_pop_cyc, last_pop_cyc;
    bit          started, watch_pop, watch_hit;
    logic [31:0] model_pc, last_req_addr, watch_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return 32'h1000 + (addr >> 2);
    endfunction

    // One clock cycle: memory model drives its response, the bench checks
    // the DUT's outputs against the model and records the handshakes that
    // the coming edge commits.
    task automatic step();
        bit          rsp_now, rsp_live, pop_now, req_now, exp_req;
        int unsigned live_inflight;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        if (mem_pipe.size() != 0 && mem_pipe[0].due <= cyc) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mem_word(mem_pipe[0].addr);
        end
        #1;
        live_inflight = 0;
        foreach (mem_pipe[i]) if (mem_pipe[i].tag == epoch) live_inflight++;
        rsp_now  = mem_rsp_valid;
        rsp_live = rsp_now && (mem_pipe[0].tag == epoch);
        pop_now  = inst_valid && inst_ready && !redirect_valid;
        req_now  = mem_req_valid && mem_req_ready;
        exp_req  = started && !redirect_valid && ((occ + live_inflight) < DEPTH);

        checks++;
        if (mem_req_valid !== exp_req) begin
            failures++;
            $display("FAIL req_valid cyc=%0d: got %b expected %b", cyc, mem_req_valid, exp_req);
        end
        checks++;
        if (inst_valid !== (occ != 0)) begin
            failures++;
            $display("FAIL inst_valid cyc=%0d: got %b expected %b", cyc, inst_valid, (occ != 0));
        end
        if (occ == DEPTH && !inst_ready) n_stalls++;

        if (pop_now) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL pop cyc=%0d: got pc=%h data=%h expected no instruction", cyc, inst_pc, inst_data);
            end else begin
                if ({inst_pc, inst_data} !== {sb[0].pc, sb[0].insn}) begin
                    failures++;
                    $display("FAIL pop cyc=%0d: got pc=%h data=%h expected pc=%h data=%h",
                             cyc, inst_pc, inst_data, sb[0].pc, sb[0].insn);
                end
                void'(sb.pop_front());
            end
            if (n_pops == 0) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
            n_pops++;
            if (watch_pop) begin
                watch_pop = 1'b0;
                watch_hit = 1'b1;
                watch_pc  = inst_pc;
            end
        end

        if (req_now) begin
            checks++;
            if (mem_req_addr !== model_pc) begin
                failures++;
                $display("FAIL req_addr cyc=%0d: got %h expected %h", cyc, mem_req_addr, model_pc);
            end
            sb.push_back('{pc: model_pc, insn: mem_word(model_pc)});
            mem_pipe.push_back('{addr: mem_req_addr, due: cyc + lat, tag: epoch});
            model_pc      = model_pc + FETCH_BYTES;
            last_req_addr = mem_req_addr;
            n_reqs++;
        end

        if (rsp_now) void'(mem_pipe.pop_front());

        if (redirect_valid) begin
            occ      = 0;
            epoch++;
            sb.delete();
            model_pc = redirect_pc & ~32'h3;
            n_redirects++;
        end else begin
            occ = occ + (rsp_live ? 1 : 0) - (pop_now ? 1 : 0);
        end

        @(posedge clk);
        cyc++;
        started = 1'b1;
        @(negedge clk);
    endtask

    task automatic assert_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mem_rsp_valid  = 1'b0;
        mem_rsp_data   = '0;
        mem_pipe.delete();
        sb.delete();
        occ = 0; epoch++; model_pc = 32'h0; started = 1'b0; cyc = 0;
        n_pops = 0; n_redirects = 0; n_stalls = 0; n_reqs = 0;
        watch_pop = 1'b0; watch_hit = 1'b0;
    endtask

    task automatic do_reset();
        assert_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_until_pops(input int unsigned target, input int unsigned budget, input string name);
        int unsigned n = 0;
        while (n_pops < target && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (n_pops < target) begin
            failures++;
            $display("FAIL %s timeout: got %0d pops expected %0d", name, n_pops, target);
        end
    endtask

    task automatic check_next_req(input logic [31:0] addr, input string name);
        #1;
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== addr) begin
            failures++;
            $display("FAIL %s: got valid=%b addr=%h expected valid=1 addr=%h", name, mem_req_valid, mem_req_addr, addr);
        end
    endtask

    task automatic check_watch(input logic [31:0] pc, input string name);
        checks++;
        if (!watch_hit || watch_pc !== pc) begin
            failures++;
            $display("FAIL %s: got seen=%b pc=%h expected pc=%h", name, watch_hit, watch_pc, pc);
        end
    endtask

    task automatic check_outputs_idle(input string name);
        checks++;
        if ({mem_req_valid, inst_valid, inst_pc, inst_data} !== '0) begin
            failures++;
            $display("FAIL %s: got req_valid=%b inst_valid=%b pc=%h data=%h expected all zero",
                     name, mem_req_valid, inst_valid, inst_pc, inst_data);
        end
    endtask

    task automatic test_reset();
        inst_ready    = 1'b0;
        mem_req_ready = 1'b1;
        lat           = 1;
        assert_reset();
        repeat (2) @(negedge clk);
        #1;
        check_outputs_idle("reset_outputs");
        rst_n = 1'b1;
        step();
        check_next_req(32'h0, "first_request");
    endtask

    task automatic test_stream();
        inst_ready = 1'b1;
        run_until_pops(4, 20, "stream");
        checks++;
        if (first_pop_cyc != 3 || last_pop_cyc != first_pop_cyc + 3) begin
            failures++;
            $display("FAIL stream_timing: got pops at cycles %0d..%0d expected 3..6", first_pop_cyc, last_pop_cyc);
        end
    endtask

    task automatic test_reset_mid();
        repeat (2) step();
        rst_n = 1'b0;
        #1;
        check_outputs_idle("reset_mid");
        do_reset();
        inst_ready = 1'b1;
        run_until_pops(3, 20, "after_reset_mid");
    endtask

    task automatic test_backpressure();
        int unsigned base, n;
        bit          got;
        logic [31:0] first_addr;
        do_reset();
        inst_ready = 1'b0;
        lat        = 1;
        repeat (12) step();
        checks++;
        if (n_reqs != 4 || mem_req_valid !== 1'b0 || inst_valid !== 1'b1) begin
            failures++;
            $display("FAIL backpressure_hold: got reqs=%0d req_valid=%b inst_valid=%b expected 4 0 1",
                     n_reqs, mem_req_valid, inst_valid);
        end
        inst_ready = 1'b1;
        base = n_reqs;
        got  = 1'b0;
        first_addr = '0;
        n = 0;
        while ((n_pops < 4 || !got) && n < 20) begin
            step();
            if (!got && n_reqs > base) begin
                got = 1'b1;
                first_addr = last_req_addr;
            end
            n++;
        end
        checks++;
        if (n_pops < 4 || !got || first_addr !== 32'h10) begin
            failures++;
            $display("FAIL backpressure_resume: got pops=%0d addr=%h expected pops=4 addr=00000010", n_pops, first_addr);
        end
    endtask

    task automatic test_stale_drop();
        do_reset();
        inst_ready = 1'b1;
        lat        = 3;
        repeat (3) step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        watch_pop      = 1'b1;
        step();
        redirect_valid = 1'b0;
        check_next_req(32'h100, "stale_next_req");
        run_until_pops(3, 30, "stale_drop");
        check_watch(32'h100, "stale_first_pc");
    endtask

    task automatic test_redirect_vs_pop();
        int unsigned n = 0;
        do_reset();
        inst_ready = 1'b0;
        lat        = 1;
        while (occ != DEPTH && n < 12) begin
            step();
            n++;
        end
        checks++;
        if (inst_valid !== 1'b1 || occ != DEPTH) begin
            failures++;
            $display("FAIL redirect_pop_fill: got inst_valid=%b occ=%0d expected 1 %0d", inst_valid, occ, DEPTH);
        end
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        watch_pop      = 1'b1;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL redirect_pop_flush: got inst_valid=%b expected 0", inst_valid);
        end
        check_next_req(32'h200, "redirect_pop_target");
        run_until_pops(2, 20, "redirect_pop");
        check_watch(32'h200, "redirect_pop_first_pc");
    endtask

    task automatic test_back_to_back();
        do_reset();
        inst_ready = 1'b1;
        lat        = 3;
        repeat (3) step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        watch_pop      = 1'b1;
        step();
        redirect_pc    = 32'h406;
        step();
        redirect_valid = 1'b0;
        check_next_req(32'h404, "b2b_next_req");
        run_until_pops(4, 30, "back_to_back");
        check_watch(32'h404, "b2b_first_pc");
    endtask

`ifdef IFETCH_PERF_EN
    task automatic test_perf();
        int unsigned n = 0;
        do_reset();
        inst_ready = 1'b0;
        lat        = 1;
        while (n_stalls < 5 && n < 20) begin
            step();
            n++;
        end
        inst_ready = 1'b1;
        run_until_pops(4, 20, "perf_a");
        redirect_valid = 1'b1;
        redirect_pc    = 32'h500;
        step();
        redirect_valid = 1'b0;
        run_until_pops(10, 30, "perf_b");
        redirect_valid = 1'b1;
        redirect_pc    = 32'h600;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (perf_fetched !== 32'(n_pops) || perf_redirects !== 32'(n_redirects) || perf_stall !== 32'(n_stalls)) begin
            failures++;
            $display("FAIL perf: got %0d/%0d/%0d expected %0d/%0d/%0d",
                     perf_fetched, perf_redirects, perf_stall, n_pops, n_redirects, n_stalls);
        end
    endtask
`endif

    initial begin
        epoch = 0;
        test_reset();
        test_stream();
        test_reset_mid();
        test_backpressure();
        test_stale_drop();
        test_redirect_vs_pop();
        test_back_to_back();
`ifdef IFETCH_PERF_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
